// File: rtl/bob_ctrl.sv
// Sequencer for the branch ordering buffer: head/tail bookkeeping, in-order
// retire, and the mispredict recovery walk (read saved state, restore, flush).
module bob_ctrl #(
   parameter int DEPTH    = 16,
   parameter int LOGDEPTH = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                alloc_req_i,
   output logic                alloc_gnt_o,
   output logic [LOGDEPTH-1:0] alloc_tag_o,
   output logic                buf_we_o,
   output logic [LOGDEPTH-1:0] buf_windex_o,
   output logic [LOGDEPTH-1:0] buf_rindex_o,
   input  logic                retire_vld_i,
   output logic                retire_rdy_o,
   input  logic                mispred_vld_i,
   input  logic [LOGDEPTH-1:0] mispred_tag_i,
   output logic                restore_vld_o,
   output logic                flush_o,
   output logic                stall_o,
   output logic [LOGDEPTH:0]   count_o,
   output logic                empty_o,
   output logic                full_o,
   output logic                err_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD      = 2'd1,
      RESTORE = 2'd2,
      FLUSH   = 2'd3
   } state_t;

   localparam logic [LOGDEPTH:0] FULL_COUNT = DEPTH[LOGDEPTH:0];

   state_t              state, state_nxt;
   logic [LOGDEPTH:0]   head, head_nxt;
   logic [LOGDEPTH:0]   tail, tail_nxt;
   logic [LOGDEPTH:0]   count;
   logic [LOGDEPTH-1:0] cap_tag, cap_tag_nxt;
   logic [LOGDEPTH-1:0] mis_age;
   logic [LOGDEPTH-1:0] cap_age;
   logic                err, err_nxt;
   logic                full, empty;
   logic                tag_valid, tag_older;
   logic                retire_fire;

   // Pointers carry a wrap bit so a completely full buffer is distinguishable from empty.
   assign count       = tail - head;
   assign full        = (count == FULL_COUNT);
   assign empty       = (count == '0);

   assign mis_age     = mispred_tag_i - head[LOGDEPTH-1:0];
   assign cap_age     = cap_tag - head[LOGDEPTH-1:0];
   assign tag_valid   = ({1'b0, mis_age} < count);
   assign tag_older   = (mis_age < cap_age);

   assign alloc_gnt_o  = alloc_req_i & ~full & (state == IDLE) & ~mispred_vld_i;
   assign retire_rdy_o = (state == IDLE) & ~empty & ~mispred_vld_i;
   assign retire_fire  = retire_rdy_o & retire_vld_i;

   always_comb begin
      state_nxt   = state;
      head_nxt    = head;
      tail_nxt    = tail;
      cap_tag_nxt = cap_tag;
      err_nxt     = err | (retire_vld_i & empty);

      case (state)
         IDLE: begin
            if (alloc_gnt_o) tail_nxt = tail + 1'b1;
            if (retire_fire) head_nxt = head + 1'b1;
            if (mispred_vld_i) begin
               if (tag_valid) begin
                  cap_tag_nxt = mispred_tag_i;
                  tail_nxt    = head + {1'b0, mis_age} + 1'b1;
                  state_nxt   = RD;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         RD, RESTORE: begin
            state_nxt = (state == RD) ? RESTORE : FLUSH;
            // Only an older branch can override; younger ones are already squashed.
            if (mispred_vld_i && tag_valid && tag_older) begin
               cap_tag_nxt = mispred_tag_i;
               tail_nxt    = head + {1'b0, mis_age} + 1'b1;
               state_nxt   = RD;
            end
         end
         FLUSH: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         head    <= '0;
         tail    <= '0;
         cap_tag <= '0;
         err     <= 1'b0;
      end else begin
         state   <= state_nxt;
         head    <= head_nxt;
         tail    <= tail_nxt;
         cap_tag <= cap_tag_nxt;
         err     <= err_nxt;
      end
   end

   assign alloc_tag_o   = tail[LOGDEPTH-1:0];
   assign buf_we_o      = alloc_gnt_o;
   assign buf_windex_o  = tail[LOGDEPTH-1:0];
   // The RAM read is registered, so the captured entry shows up on the data bus in RESTORE.
   assign buf_rindex_o  = ((state == RD) || (state == RESTORE)) ? cap_tag : head[LOGDEPTH-1:0];
   assign restore_vld_o = (state == RESTORE);
   assign flush_o       = (state == FLUSH);
   assign stall_o       = full | (state != IDLE);
   assign count_o       = count;
   assign empty_o       = empty;
   assign full_o        = full;
   assign err_o         = err;

endmodule

// File: tb/tb_bob_ctrl.sv
// Directed bench for bob_ctrl: fill/wrap, recovery sequencing, recapture,
// protocol errors and reset during recovery.
module tb_bob_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       alloc_req_i = 1'b0;
   logic       alloc_gnt_o;
   logic [3:0] alloc_tag_o;
   logic       buf_we_o;
   logic [3:0] buf_windex_o;
   logic [3:0] buf_rindex_o;
   logic       retire_vld_i = 1'b0;
   logic       retire_rdy_o;
   logic       mispred_vld_i = 1'b0;
   logic [3:0] mispred_tag_i = 4'd0;
   logic       restore_vld_o;
   logic       flush_o;
   logic       stall_o;
   logic [4:0] count_o;
   logic       empty_o;
   logic       full_o;
   logic       err_o;

   int n_checks = 0;
   int n_fails  = 0;

   bob_ctrl #(.DEPTH(16), .LOGDEPTH(4)) dut (
      .clock(clock), .reset(reset),
      .alloc_req_i(alloc_req_i), .alloc_gnt_o(alloc_gnt_o), .alloc_tag_o(alloc_tag_o),
      .buf_we_o(buf_we_o), .buf_windex_o(buf_windex_o), .buf_rindex_o(buf_rindex_o),
      .retire_vld_i(retire_vld_i), .retire_rdy_o(retire_rdy_o),
      .mispred_vld_i(mispred_vld_i), .mispred_tag_i(mispred_tag_i),
      .restore_vld_o(restore_vld_o), .flush_o(flush_o), .stall_o(stall_o),
      .count_o(count_o), .empty_o(empty_o), .full_o(full_o), .err_o(err_o)
   );

   always #5 clock = ~clock;

   task automatic clear_inputs();
      alloc_req_i   = 1'b0;
      retire_vld_i  = 1'b0;
      mispred_vld_i = 1'b0;
      mispred_tag_i = 4'd0;
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
   endtask

   task automatic alloc_n(input int n);
      for (int i = 0; i < n; i++) begin
         alloc_req_i = 1'b1;
         next_cycle();
      end
      alloc_req_i = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_checks++; if (count_o !== 5'd0) begin n_fails++; $display("[TB] FAIL reset_count: got %0d expected 0", count_o); end
      n_checks++; if (empty_o !== 1'b1) begin n_fails++; $display("[TB] FAIL reset_empty: got %b expected 1", empty_o); end
      n_checks++; if (full_o !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_full: got %b expected 0", full_o); end
      n_checks++; if (stall_o !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_stall: got %b expected 0", stall_o); end
      n_checks++; if (err_o !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_err: got %b expected 0", err_o); end
      n_checks++; if ({flush_o, restore_vld_o} !== 2'b00) begin n_fails++; $display("[TB] FAIL reset_flush_restore: got %b expected 00", {flush_o, restore_vld_o}); end
      n_checks++; if (retire_rdy_o !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_retire_rdy: got %b expected 0", retire_rdy_o); end
      n_checks++; if (buf_rindex_o !== 4'd0) begin n_fails++; $display("[TB] FAIL reset_rindex: got %0d expected 0", buf_rindex_o); end
      next_cycle();
      reset = 1'b0;
   endtask

   task automatic test_fill();
      for (int i = 0; i < 16; i++) begin
         alloc_req_i = 1'b1;
         #1;
         n_checks++; if (alloc_gnt_o !== 1'b1 || buf_we_o !== 1'b1) begin n_fails++; $display("[TB] FAIL fill_gnt[%0d]: got gnt=%b we=%b expected 1", i, alloc_gnt_o, buf_we_o); end
         n_checks++; if (alloc_tag_o !== 4'(i) || buf_windex_o !== 4'(i)) begin n_fails++; $display("[TB] FAIL fill_tag[%0d]: got tag=%0d windex=%0d expected %0d", i, alloc_tag_o, buf_windex_o, i); end
         next_cycle();
      end
      #1;
      n_checks++; if (count_o !== 5'd16) begin n_fails++; $display("[TB] FAIL fill_count: got %0d expected 16", count_o); end
      n_checks++; if (full_o !== 1'b1 || stall_o !== 1'b1) begin n_fails++; $display("[TB] FAIL fill_full_stall: got full=%b stall=%b expected 1 1", full_o, stall_o); end
      n_checks++; if (alloc_gnt_o !== 1'b0) begin n_fails++; $display("[TB] FAIL fill_17th_gnt: got %b expected 0", alloc_gnt_o); end
      alloc_req_i = 1'b0;
   endtask

   task automatic test_full_wrap();
      alloc_req_i  = 1'b1;
      retire_vld_i = 1'b1;
      #1;
      n_checks++; if (retire_rdy_o !== 1'b1) begin n_fails++; $display("[TB] FAIL wrap_retire_rdy: got %b expected 1", retire_rdy_o); end
      n_checks++; if (alloc_gnt_o !== 1'b0) begin n_fails++; $display("[TB] FAIL wrap_alloc_blocked: got %b expected 0", alloc_gnt_o); end
      next_cycle();
      retire_vld_i = 1'b0;
      #1;
      n_checks++; if (count_o !== 5'd15) begin n_fails++; $display("[TB] FAIL wrap_count15: got %0d expected 15", count_o); end
      n_checks++; if (alloc_gnt_o !== 1'b1 || alloc_tag_o !== 4'd0) begin n_fails++; $display("[TB] FAIL wrap_tag0: got gnt=%b tag=%0d expected 1 0", alloc_gnt_o, alloc_tag_o); end
      n_checks++; if (buf_rindex_o !== 4'd1) begin n_fails++; $display("[TB] FAIL wrap_head_rindex: got %0d expected 1", buf_rindex_o); end
      next_cycle();
      alloc_req_i = 1'b0;
      n_checks++; if (count_o !== 5'd16 || full_o !== 1'b1) begin n_fails++; $display("[TB] FAIL wrap_refull: got count=%0d full=%b expected 16 1", count_o, full_o); end
   endtask

   task automatic test_mispredict();
      do_reset();
      alloc_n(6);
      alloc_req_i   = 1'b1;
      retire_vld_i  = 1'b1;
      mispred_vld_i = 1'b1;
      mispred_tag_i = 4'd2;
      #1;
      n_checks++; if (alloc_gnt_o !== 1'b0 || retire_rdy_o !== 1'b0) begin n_fails++; $display("[TB] FAIL mis_wins: got gnt=%b rdy=%b expected 0 0", alloc_gnt_o, retire_rdy_o); end
      next_cycle();
      clear_inputs();
      n_checks++; if (buf_rindex_o !== 4'd2 || stall_o !== 1'b1 || restore_vld_o !== 1'b0) begin n_fails++; $display("[TB] FAIL mis_rd: got rindex=%0d stall=%b restore=%b expected 2 1 0", buf_rindex_o, stall_o, restore_vld_o); end
      n_checks++; if (count_o !== 5'd3) begin n_fails++; $display("[TB] FAIL mis_squash_count: got %0d expected 3", count_o); end
      next_cycle();
      n_checks++; if (restore_vld_o !== 1'b1 || flush_o !== 1'b0 || buf_rindex_o !== 4'd2) begin n_fails++; $display("[TB] FAIL mis_restore: got restore=%b flush=%b rindex=%0d expected 1 0 2", restore_vld_o, flush_o, buf_rindex_o); end
      next_cycle();
      n_checks++; if (flush_o !== 1'b1 || restore_vld_o !== 1'b0) begin n_fails++; $display("[TB] FAIL mis_flush: got flush=%b restore=%b expected 1 0", flush_o, restore_vld_o); end
      next_cycle();
      n_checks++; if (flush_o !== 1'b0 || stall_o !== 1'b0 || count_o !== 5'd3) begin n_fails++; $display("[TB] FAIL mis_idle: got flush=%b stall=%b count=%0d expected 0 0 3", flush_o, stall_o, count_o); end
      n_checks++; if (alloc_tag_o !== 4'd3) begin n_fails++; $display("[TB] FAIL mis_next_tag: got %0d expected 3", alloc_tag_o); end
   endtask

   task automatic test_recapture();
      do_reset();
      alloc_n(6);
      mispred_vld_i = 1'b1;
      mispred_tag_i = 4'd4;
      next_cycle();
      n_checks++; if (buf_rindex_o !== 4'd4 || count_o !== 5'd5) begin n_fails++; $display("[TB] FAIL recap_first: got rindex=%0d count=%0d expected 4 5", buf_rindex_o, count_o); end
      mispred_tag_i = 4'd1;
      next_cycle();
      mispred_vld_i = 1'b0;
      n_checks++; if (buf_rindex_o !== 4'd1 || restore_vld_o !== 1'b0 || count_o !== 5'd2) begin n_fails++; $display("[TB] FAIL recap_older: got rindex=%0d restore=%b count=%0d expected 1 0 2", buf_rindex_o, restore_vld_o, count_o); end
      next_cycle();
      n_checks++; if (restore_vld_o !== 1'b1 || buf_rindex_o !== 4'd1) begin n_fails++; $display("[TB] FAIL recap_restore: got restore=%b rindex=%0d expected 1 1", restore_vld_o, buf_rindex_o); end
      mispred_vld_i = 1'b1;
      mispred_tag_i = 4'd5;
      next_cycle();
      clear_inputs();
      n_checks++; if (flush_o !== 1'b1 || count_o !== 5'd2) begin n_fails++; $display("[TB] FAIL recap_young_ignored: got flush=%b count=%0d expected 1 2", flush_o, count_o); end
      next_cycle();
      n_checks++; if (stall_o !== 1'b0 || flush_o !== 1'b0 || count_o !== 5'd2 || alloc_tag_o !== 4'd2) begin n_fails++; $display("[TB] FAIL recap_idle: got stall=%b flush=%b count=%0d tag=%0d expected 0 0 2 2", stall_o, flush_o, count_o, alloc_tag_o); end
   endtask

   task automatic test_errors();
      do_reset();
      n_checks++; if (err_o !== 1'b0) begin n_fails++; $display("[TB] FAIL err_clear: got %b expected 0", err_o); end
      retire_vld_i = 1'b1;
      #1;
      n_checks++; if (retire_rdy_o !== 1'b0) begin n_fails++; $display("[TB] FAIL err_empty_rdy: got %b expected 0", retire_rdy_o); end
      next_cycle();
      retire_vld_i = 1'b0;
      n_checks++; if (err_o !== 1'b1 || count_o !== 5'd0) begin n_fails++; $display("[TB] FAIL err_set: got err=%b count=%0d expected 1 0", err_o, count_o); end
      alloc_n(3);
      n_checks++; if (err_o !== 1'b1) begin n_fails++; $display("[TB] FAIL err_sticky: got %b expected 1", err_o); end
      mispred_vld_i = 1'b1;
      mispred_tag_i = 4'd9;
      next_cycle();
      clear_inputs();
      n_checks++; if (count_o !== 5'd3 || stall_o !== 1'b0 || alloc_tag_o !== 4'd3 || buf_rindex_o !== 4'd0) begin n_fails++; $display("[TB] FAIL err_bad_tag_ignored: got count=%0d stall=%b tag=%0d rindex=%0d expected 3 0 3 0", count_o, stall_o, alloc_tag_o, buf_rindex_o); end
      n_checks++; if (err_o !== 1'b1) begin n_fails++; $display("[TB] FAIL err_bad_tag_err: got %b expected 1", err_o); end
   endtask

   task automatic test_reset_in_recovery();
      int flush_seen;
      do_reset();
      alloc_n(6);
      mispred_vld_i = 1'b1;
      mispred_tag_i = 4'd2;
      next_cycle();
      clear_inputs();
      next_cycle();
      n_checks++; if (restore_vld_o !== 1'b1) begin n_fails++; $display("[TB] FAIL rstrec_in_restore: got %b expected 1", restore_vld_o); end
      #2;
      reset = 1'b1;
      #1;
      n_checks++; if (count_o !== 5'd0 || empty_o !== 1'b1 || restore_vld_o !== 1'b0 || stall_o !== 1'b0) begin n_fails++; $display("[TB] FAIL rstrec_async: got count=%0d empty=%b restore=%b stall=%b expected 0 1 0 0", count_o, empty_o, restore_vld_o, stall_o); end
      flush_seen = 0;
      @(negedge clock);
      if (flush_o) flush_seen++;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         if (flush_o || restore_vld_o) flush_seen++;
      end
      n_checks++; if (flush_seen !== 0) begin n_fails++; $display("[TB] FAIL rstrec_no_flush: got %0d pulses expected 0", flush_seen); end
      alloc_req_i = 1'b1;
      #1;
      n_checks++; if (alloc_gnt_o !== 1'b1 || alloc_tag_o !== 4'd0) begin n_fails++; $display("[TB] FAIL rstrec_tag0: got gnt=%b tag=%0d expected 1 0", alloc_gnt_o, alloc_tag_o); end
      next_cycle();
      clear_inputs();
      n_checks++; if (count_o !== 5'd1) begin n_fails++; $display("[TB] FAIL rstrec_count: got %0d expected 1", count_o); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_full_wrap();
      test_mispredict();
      test_recapture();
      test_errors();
      test_reset_in_recovery();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/bob_ctrl.md
Name: bob_ctrl

Overview:
- Sequencer for the 16-entry branch ordering buffer RAM.
- Manages head/tail pointers and occupancy, and hands out entry tags to fetch as branches are inserted.
- Retires entries in order at commit.
- On a branch misprediction: squashes all younger entries, reads back the mispredicted entry's saved predictor state (BHR, BHT, RAS pointer), then pulses a front-end flush.
- Sits between fetch, the retire unit and the buffer RAM; the RAM has a registered read with 1-cycle latency.

Parameters:
DEPTH, 16, number of buffer entries; must be a power of two
LOGDEPTH, 4, log2(DEPTH); width of tags and RAM indices

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
alloc_req_i  input  1  fetch requests insertion of a branch entry
alloc_gnt_o  output  1  insertion accepted this cycle
alloc_tag_o  output  LOGDEPTH  tag of the entry being inserted (equals tail)
buf_we_o  output  1  buffer RAM write enable (equals alloc_gnt_o)
buf_windex_o  output  LOGDEPTH  buffer RAM write index (equals tail)
buf_rindex_o  output  LOGDEPTH  buffer RAM read index
retire_vld_i  input  1  oldest branch commits
retire_rdy_o  output  1  retire accepted this cycle
mispred_vld_i  input  1  branch resolved as mispredicted
mispred_tag_i  input  LOGDEPTH  tag of the mispredicted branch
restore_vld_o  output  1  RAM read data holds the mispredicted entry; predictor restores from it
flush_o  output  1  one-cycle front-end flush pulse
stall_o  output  1  fetch must hold
count_o  output  LOGDEPTH+1  occupied entries, 0..DEPTH
empty_o  output  1  count_o == 0
full_o  output  1  count_o == DEPTH
err_o  output  1  sticky protocol-error flag

Behaviour:
- State: head and tail pointers, each LOGDEPTH+1 bits (MSB is the wrap bit).
  - count = tail - head, modulo 2^(LOGDEPTH+1).
  - The entry index is the low LOGDEPTH bits of the pointer.
  - Wrap from 15 to 0 is natural; a full buffer holds all 16 entries (no lost slot).
- Reset (asynchronous, any state):
  - head = tail = 0, FSM = IDLE, err_o = 0.
  - All outputs read 0 except empty_o = 1 and stall_o = 0.
  - Reset during recovery abandons it; no restore or flush pulse is issued.
- FSM states:
  - IDLE: normal allocate and retire.
  - RD: buf_rindex_o = captured tag.
  - RESTORE: restore_vld_o = 1.
  - FLUSH: flush_o = 1.
- FSM transitions: IDLE -> RD -> RESTORE -> FLUSH -> IDLE, one cycle each.
- Tag validity: age = (mispred_tag_i - head[LOGDEPTH-1:0]) mod DEPTH; the tag is valid iff age < count.
- Mispredict accepted in IDLE with a valid tag:
  - Capture the tag, set tail = head + age + 1 (all younger entries squashed), enter RD.
- Mispredict with an invalid tag: ignored, err_o set.
- Mispredict during RD or RESTORE with a valid tag older than the captured tag (smaller age):
  - Recapture that tag, recompute tail, re-enter RD.
  - A younger or equal tag is ignored. Any mispredict during FLUSH is ignored.
- alloc_gnt_o = alloc_req_i & ~full & (state == IDLE) & ~mispred_vld_i. A mispredict wins over allocation in the same cycle.
- retire_rdy_o = (state == IDLE) & ~empty & ~mispred_vld_i.
  - A retire accepted via retire_rdy_o advances head by 1.
  - retire_vld_i while empty sets err_o.
  - A retire blocked by recovery or a simultaneous mispredict must be held by the requester (not an error).
- Simultaneous alloc and retire: both take effect and count is unchanged.
  - When full, alloc is blocked even if a retire occurs the same cycle (the decision uses the registered count).
- buf_rindex_o = head in IDLE and FLUSH; captured tag in RD and RESTORE.
  - RAM data corresponding to RD is valid in RESTORE.
- stall_o = full | (state != IDLE).
- flush_o and restore_vld_o are asserted for exactly one cycle per completed recovery.
- All outputs other than alloc_gnt_o, buf_we_o and retire_rdy_o are registered or decoded from registered state.
  - alloc_gnt_o, buf_we_o and retire_rdy_o are combinational from inputs plus state.

Test Plan:
- Reset, then 16 back-to-back alloc_req_i -> tags 0..15 issued, count_o = 16, full_o = 1, stall_o = 1; 17th request gets alloc_gnt_o = 0.
- From full, retire and alloc in the same cycle -> retire accepted, alloc refused; next cycle alloc accepted with tag 0 (wrap), count_o back to 16.
- 6 entries allocated (head 0), mispred_tag_i = 2 -> RD with buf_rindex_o = 2; restore_vld_o next cycle; flush_o the cycle after; then IDLE with count_o = 3 and next alloc tag = 3.
- Mispred tag 4 accepted; during RD a mispred with tag 1 -> recapture, buf_rindex_o = 1, final count_o = 2; a tag-5 mispred during RESTORE is ignored.
- retire_vld_i while empty -> err_o = 1 and stays 1; mispred tag 9 with count 3 -> ignored, no state change.
- Assert reset during RESTORE -> no flush_o pulse, count_o = 0, empty_o = 1, FSM IDLE; next alloc returns tag 0.
